conversor_bin_bcd: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock.
- Sits directly upstream of the display digit multiplexer.
- Its registered output reg_cifrasBCD feeds the multiplexer's BCD register input. Digit 0 (least significant) is in bits [3:0].
- The output is held stable between conversions, so the multiplexer can scan it on its own 1 ms tick.

---
 rtl/conversor_bin_bcd.sv | 126 ++++++++++++
 tb/tb_conversor_bin_bcd.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional build macro BCD_BLANK_CEROS_EN: leading zero digits are written as 4'hF (blank code).
module conversor_bin_bcd #(
    parameter  int ANCHO_BIN   = 12,
    localparam int TAM_REG_BCD = ANCHO_BIN + 4,
    localparam int CANT_CIFRAS = TAM_REG_BCD / 4
) (
    input  logic                   reloj,
    input  logic                   reset_n,
    input  logic [ANCHO_BIN-1:0]   dato_bin,
    input  logic                   inicio,
    output logic                   ocupado,
    output logic                   listo,
    output logic [TAM_REG_BCD-1:0] reg_cifrasBCD
);

    localparam int ANCHO_CUENTA = $clog2(ANCHO_BIN + 1);

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] DESPLAZA = 2'd1;
    localparam logic [1:0] FIN      = 2'd2;

    logic [1:0]              estado_r;
    logic [ANCHO_BIN-1:0]    desp_bin_r;
    logic [TAM_REG_BCD-1:0]  acum_bcd_r;
    logic [ANCHO_CUENTA-1:0] cuenta_r;

    logic [TAM_REG_BCD-1:0]  acum_ajustado_s;
    logic [TAM_REG_BCD-1:0]  acum_siguiente_s;
    logic [ANCHO_BIN-1:0]    desp_siguiente_s;
    logic [TAM_REG_BCD-1:0]  resultado_s;

    // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
    function automatic logic [TAM_REG_BCD-1:0] ajusta_bcd(input logic [TAM_REG_BCD-1:0] valor);
        logic [TAM_REG_BCD-1:0] res;
        res = valor;
        for (int i = 0; i < CANT_CIFRAS; i++) begin
            if (valor[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = valor[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = valor[4*i +: 4];
            end
        end
        return res;
    endfunction

`ifdef BCD_BLANK_CEROS_EN
    // Digit 0 is always kept so a zero result still shows one digit.
    function automatic logic [TAM_REG_BCD-1:0] blanquea_ceros(input logic [TAM_REG_BCD-1:0] valor);
        logic [TAM_REG_BCD-1:0] res;
        logic                   lider;
        res   = valor;
        lider = 1'b1;
        for (int i = CANT_CIFRAS - 1; i >= 1; i--) begin
            if (lider && (valor[4*i +: 4] == 4'd0)) begin
                res[4*i +: 4] = 4'hF;
            end else begin
                lider = 1'b0;
            end
        end
        return res;
    endfunction
`endif

    // One double-dabble step: adjust digits, then shift {acum, desp} left by one.
    always_comb begin
        acum_ajustado_s  = ajusta_bcd(acum_bcd_r);
        acum_siguiente_s = {acum_ajustado_s[TAM_REG_BCD-2:0], desp_bin_r[ANCHO_BIN-1]};
        desp_siguiente_s = {desp_bin_r[ANCHO_BIN-2:0], 1'b0};
`ifdef BCD_BLANK_CEROS_EN
        resultado_s      = blanquea_ceros(acum_bcd_r);
`else
        resultado_s      = acum_bcd_r;
`endif
    end

    // Control FSM and datapath registers; reg_cifrasBCD only updates in FIN.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            estado_r      <= REPOSO;
            desp_bin_r    <= '0;
            acum_bcd_r    <= '0;
            cuenta_r      <= '0;
            ocupado       <= 1'b0;
            listo         <= 1'b0;
            reg_cifrasBCD <= '0;
        end else begin
            listo <= 1'b0;
            case (estado_r)
                REPOSO: begin
                    if (inicio) begin
                        desp_bin_r <= dato_bin;
                        acum_bcd_r <= '0;
                        cuenta_r   <= ANCHO_CUENTA'(ANCHO_BIN);
                        ocupado    <= 1'b1;
                        estado_r   <= DESPLAZA;
                    end else begin
                        ocupado    <= 1'b0;
                        estado_r   <= REPOSO;
                    end
                end
                DESPLAZA: begin
                    acum_bcd_r <= acum_siguiente_s;
                    desp_bin_r <= desp_siguiente_s;
                    cuenta_r   <= cuenta_r - ANCHO_CUENTA'(1);
                    if (cuenta_r == ANCHO_CUENTA'(1)) begin
                        estado_r <= FIN;
                    end else begin
                        estado_r <= DESPLAZA;
                    end
                end
                FIN: begin
                    reg_cifrasBCD <= resultado_s;
                    listo         <= 1'b1;
                    ocupado       <= 1'b0;
                    estado_r      <= REPOSO;
                end
                default: begin
                    ocupado  <= 1'b0;
                    estado_r <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Self-checking bench for conversor_bin_bcd (ANCHO_BIN=12): directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_conversor_bin_bcd;

    logic        reloj;
    logic        reset_n;
    logic [11:0] dato_bin;
    logic        inicio;
    logic        ocupado;
    logic        listo;
    logic [15:0] reg_cifrasBCD;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_reg;

    conversor_bin_bcd #(.ANCHO_BIN(12)) dut (
        .reloj         (reloj),
        .reset_n       (reset_n),
        .dato_bin      (dato_bin),
        .inicio        (inicio),
        .ocupado       (ocupado),
        .listo         (listo),
        .reg_cifrasBCD (reg_cifrasBCD)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    // Reference: decimal digits by division, then optional leading-zero blanking.
    function automatic logic [15:0] bcd_ref(input int valor);
        logic [15:0] r;
        int          div;
        logic        lider;
        div = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((valor / div) % 10);
            div = div * 10;
        end
`ifdef BCD_BLANK_CEROS_EN
        lider = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lider && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
            else lider = 1'b0;
        end
`else
        lider = 1'b0;
`endif
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Full conversion; called at a negedge. Optionally injects ignored start requests at edges 3 and 13.
    task automatic convertir(input logic [11:0] v, input bit intruso);
        logic [15:0] prev;
        logic [15:0] esperado;
        prev     = exp_reg;
        esperado = bcd_ref(int'(v));
        dato_bin = v;
        inicio   = 1'b1;
        @(posedge reloj);
        for (int i = 0; i <= 12; i++) begin
            @(negedge reloj);
            check_val("ocupado_conv", 32'(ocupado), 32'd1);
            check_val("listo_conv", 32'(listo), 32'd0);
            check_val("reg_hold", 32'(reg_cifrasBCD), 32'(prev));
            if (intruso && (i == 2 || i == 12)) begin
                inicio   = 1'b1;
                dato_bin = 12'd999;
            end else begin
                inicio   = 1'b0;
                dato_bin = 12'($urandom);
            end
        end
        @(negedge reloj);
        check_val("listo_pulse", 32'(listo), 32'd1);
        check_val("ocupado_done", 32'(ocupado), 32'd0);
        check_val("result", 32'(reg_cifrasBCD), 32'(esperado));
        inicio = 1'b0;
        @(negedge reloj);
        check_val("listo_drop", 32'(listo), 32'd0);
        check_val("ocupado_idle", 32'(ocupado), 32'd0);
        check_val("result_hold", 32'(reg_cifrasBCD), 32'(esperado));
        exp_reg = esperado;
    endtask

    // Held-start case: wait (bounded) for listo and check the cycle distance and result.
    task automatic espera_listo(input int esperado_ciclos, input logic [15:0] esperado);
        int  ciclos;
        bit  visto;
        ciclos = 0;
        visto  = 1'b0;
        while (!visto && ciclos < 40) begin
            @(negedge reloj);
            ciclos++;
            if (listo) visto = 1'b1;
        end
        check_val("cont_period", 32'(ciclos), 32'(esperado_ciclos));
        check_val("cont_result", 32'(reg_cifrasBCD), 32'(esperado));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        exp_reg  = 16'h0000;
        reset_n  = 1'b0;
        inicio   = 1'b0;
        dato_bin = 12'd0;
        repeat (2) @(negedge reloj);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge reloj);
            check_val("idle_reg", 32'(reg_cifrasBCD), 32'h0000);
            check_val("idle_ocupado", 32'(ocupado), 32'd0);
            check_val("idle_listo", 32'(listo), 32'd0);
        end

        convertir(12'd4095, 1'b0);
        check_val("max_4095", 32'(reg_cifrasBCD), 32'(bcd_ref(4095)));
        convertir(12'd0, 1'b0);
        convertir(12'd255, 1'b0);
        convertir(12'd1234, 1'b1);
        convertir(12'd9, 1'b0);
        convertir(12'd10, 1'b0);

        // Asynchronous reset in the middle of a conversion.
        dato_bin = 12'd4095;
        inicio   = 1'b1;
        @(posedge reloj);
        #1 inicio = 1'b0;
        repeat (6) @(posedge reloj);
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_ocupado", 32'(ocupado), 32'd0);
        check_val("rst_listo", 32'(listo), 32'd0);
        check_val("rst_reg", 32'(reg_cifrasBCD), 32'h0000);
        @(negedge reloj);
        reset_n = 1'b1;
        exp_reg = 16'h0000;
        @(negedge reloj);
        convertir(12'd7, 1'b0);

        for (int k = 0; k < 20; k++) begin
            convertir(12'($urandom_range(0, 4095)), 1'b0);
        end

        // Continuous start request: one result every 14 cycles.
        dato_bin = 12'd1000;
        inicio   = 1'b1;
        espera_listo(14, bcd_ref(1000));
        dato_bin = 12'd42;
        espera_listo(14, bcd_ref(42));
        inicio = 1'b0;
        repeat (3) @(negedge reloj);
        check_val("cont_stop", 32'(ocupado), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
